mem_port_arb: RTL and testbench

- Arbiter sharing one single-port synchronous `ram` between the instruction-fetch path and the data load/store path.
- Prerequisite for a unified code/data memory behind `cpu`.
- Grants at most one requester per cycle, drives the RAM, and routes the read data back to the requester that owns it.
- RAM read latency is one cycle: q reflects the address sampled at the previous clk edge.

---
 rtl/mem_port_arb_pkg.sv | 29 ++
 rtl/mem_port_arb_if.sv | 37 +++
 rtl/mem_port_arb_prio2.sv | 11 +
 rtl/mem_port_arb.sv | 92 +++++++++
 tb/tb_mem_port_arb.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // In-flight read tracker: which requester owns the RAM output this cycle
  typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_e;

  typedef logic [1:0] own_t;
  localparam own_t OWN_NONE = 2'd0;
  localparam own_t OWN_I    = 2'd1;
  localparam own_t OWN_D    = 2'd2;

  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W_DEF   = $clog2(MAX_WAIT_DEF + 1);

  // Wait counter width able to hold 0..max_wait
  function automatic int wait_w(int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

  // Requester whose read data is on mem_q in the given state
  function automatic own_t state_own(state_e s);
    case (s)
      RD_I:    return OWN_I;
      RD_D:    return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of fetch, data and RAM-side signals around the arbiter.
// slave = arbiter side, master = requesters plus RAM.
interface mem_port_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_d;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_ad, mem_d, mem_we
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_ad, mem_d, mem_we
  );
endinterface

// File: rtl/mem_port_arb_prio2.sv
// Two-input priority picker: hi wins unless ovr hands the cycle to lo.
module arb_prio2 (
  input  logic req_hi,
  input  logic req_lo,
  input  logic ovr,
  output logic gnt_hi,
  output logic gnt_lo
);
  assign gnt_lo = req_lo & (ovr | ~req_hi);
  assign gnt_hi = req_hi & ~gnt_lo;
endmodule

// File: rtl/mem_port_arb.sv
// Shares one single-port, 1-cycle-latency RAM between fetch and data paths.
// Data has priority; with MEM_ARB_STARVE_EN defined, a fetch that has waited
// MAX_WAIT cycles wins for one cycle.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic           clk,
  input logic           nreset,
  mem_port_arb_if.slave bus
);

  logic          if_gnt, d_gnt, starve;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          if_rvalid_q, d_rvalid_q;
  state_e        state_q, state_d;
  own_t          own;

  // No grants leave the block while reset is held
  arb_prio2 u_prio (
    .req_hi (bus.d_req & nreset),
    .req_lo (bus.if_req & nreset),
    .ovr    (starve),
    .gnt_hi (d_gnt),
    .gnt_lo (if_gnt)
  );

`ifdef MEM_ARB_STARVE_EN
  localparam int WW = wait_w(MAX_WAIT);
  logic [WW-1:0] wait_cnt;

  // Count consecutive stalled fetch cycles, saturating at MAX_WAIT
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                     wait_cnt <= '0;
    else if (!bus.if_req || if_gnt)  wait_cnt <= '0;
    else if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
  end

  assign starve = bus.if_req & (wait_cnt == WW'(MAX_WAIT));
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
  assign starve = 1'b0;
`endif

  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;
  assign mem_ad     = d_gnt ? bus.d_addr : bus.if_addr;
  assign bus.mem_ad = mem_ad;
  assign bus.mem_we = d_gnt & bus.d_we;
  assign bus.mem_d  = bus.d_wdata;

  // Remember which read, if any, was issued on this edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next owner of mem_q: load beats fetch (only one can be granted anyway)
  always_comb begin
    state_d = IDLE;
    if (d_gnt && !bus.d_we) state_d = RD_D;
    else if (if_gnt)        state_d = RD_I;
  end

  assign own = state_own(state_q);

  // Route returning RAM data to its owner; rdata holds between responses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= (own == OWN_I);
      d_rvalid_q  <= (own == OWN_D);
      if (own == OWN_I) if_rdata_q <= bus.mem_q;
      if (own == OWN_D) d_rdata_q  <= bus.mem_q;
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus random traffic, checked
// against a transaction-level model (grant rule, response queue, RAM array).
// Honors MEM_ARB_STARVE_EN the same way as the design.
module tb_mem_port_arb;
  localparam int MAXW = 4;
`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } op_t;
  typedef struct { int due; bit is_d; logic [31:0] data; } rsp_t;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  mem_port_arb_if #(.AW(32), .DW(32)) bus ();
  mem_port_arb #(.AW(32), .DW(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .nreset(nreset), .bus(bus)
  );

  // Behavioural synchronous RAM, 256 words, q = word at previous edge's address
  logic [31:0] init_ram [256];
  logic [31:0] ram [256];
  bit ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_ram[i];
      ram_ready <= 1'b1;
    end else begin
      if (bus.mem_we) ram[bus.mem_ad[9:2]] <= bus.mem_d;
      bus.mem_q <= ram[bus.mem_ad[9:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  // A pending request must stay asserted until granted
  bit hold_i, hold_d;
  always @(posedge clk) begin
    if (nreset) begin
      if (hold_i) assert (bus.if_req) else begin errors++; $error("FAIL if_req_hold observed=0 expected=1"); end
      if (hold_d) assert (bus.d_req)  else begin errors++; $error("FAIL d_req_hold observed=0 expected=1"); end
      hold_i <= bus.if_req && !bus.if_gnt;
      hold_d <= bus.d_req && !bus.d_gnt;
    end else begin
      hold_i <= 1'b0;
      hold_d <= 1'b0;
    end
  end

  // Reference model state
  logic [31:0] ref_ram [256];
  logic [31:0] f_q [$];
  op_t         d_q [$];
  rsp_t        pend [$];
  logic [31:0] e_ird, e_drd;
  int          wcnt, cyc;
  bit          d_forever, obs_ifg;

  function automatic int idx(logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: issue queued ops, check at negedge, advance the model
  task automatic step();
    bit eg_i, eg_d, erv_i, erv_d, ovr;
    rsp_t r;
    op_t  op;
    if (nreset) begin
      if (!bus.if_req && f_q.size() > 0) begin
        bus.if_addr = f_q.pop_front();
        bus.if_req  = 1'b1;
      end
      if (!bus.d_req && d_forever) d_q.push_back('{1'b0, 32'h40, 32'h0});
      if (!bus.d_req && d_q.size() > 0) begin
        op = d_q.pop_front();
        bus.d_we = op.we; bus.d_addr = op.addr; bus.d_wdata = op.wdata;
        bus.d_req = 1'b1;
      end
    end
    @(negedge clk);
    eg_i = 1'b0; eg_d = 1'b0; erv_i = 1'b0; erv_d = 1'b0;
    if (!nreset) begin
      wcnt = 0; pend.delete(); e_ird = '0; e_drd = '0;
    end else begin
      ovr  = STARVE_EN && bus.if_req && (wcnt == MAXW);
      eg_i = bus.if_req && (ovr || !bus.d_req);
      eg_d = bus.d_req && !eg_i;
    end
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.is_d) begin erv_d = 1'b1; e_drd = r.data; end
      else        begin erv_i = 1'b1; e_ird = r.data; end
    end
    obs_ifg = bus.if_gnt;
    chk("if_gnt",    32'(bus.if_gnt),    32'(eg_i));
    chk("d_gnt",     32'(bus.d_gnt),     32'(eg_d));
    chk("mem_we",    32'(bus.mem_we),    32'(eg_d && bus.d_we));
    chk("if_rvalid", 32'(bus.if_rvalid), 32'(erv_i));
    chk("d_rvalid",  32'(bus.d_rvalid),  32'(erv_d));
    chk("if_rdata",  bus.if_rdata, e_ird);
    chk("d_rdata",   bus.d_rdata,  e_drd);
    if (nreset) chk("mem_ad", bus.mem_ad, eg_d ? bus.d_addr : bus.if_addr);
    if (eg_d && bus.d_we) chk("mem_d", bus.mem_d, bus.d_wdata);
    if (eg_d && bus.d_we) ref_ram[idx(bus.d_addr)] = bus.d_wdata;
    else if (eg_d)        pend.push_back('{cyc + 2, 1'b1, ref_ram[idx(bus.d_addr)]});
    if (eg_i)             pend.push_back('{cyc + 2, 1'b0, ref_ram[idx(bus.if_addr)]});
    if (nreset) wcnt = (bus.if_req && !eg_i) ? ((wcnt < MAXW) ? wcnt + 1 : MAXW) : 0;
    @(posedge clk); #1;
    cyc++;
    if (eg_i) bus.if_req = 1'b0;
    if (eg_d) bus.d_req  = 1'b0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int first, n_ifg;
    for (int i = 0; i < 256; i++) begin
      init_ram[i] = $urandom;
      ref_ram[i]  = init_ram[i];
    end
    init_ram[idx(32'h10)] = 32'hE3A01005; ref_ram[idx(32'h10)] = 32'hE3A01005;
    init_ram[idx(32'h40)] = 32'h12345678; ref_ram[idx(32'h40)] = 32'h12345678;
    cyc = 0; wcnt = 0; e_ird = '0; e_drd = '0; d_forever = 1'b0;

    // Reset with requests pending: no grants, no writes
    nreset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h0;
    run(3);
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    nreset = 1'b1;
    run(1);

    // Single fetch
    f_q.push_back(32'h10);
    run(4);
    chk("single_fetch_data", bus.if_rdata, 32'hE3A01005);

    // Collision: load wins, fetch follows
    f_q.push_back(32'h10);
    d_q.push_back('{1'b0, 32'h40, 32'h0});
    run(5);
    chk("collision_d_rdata", bus.d_rdata, 32'h12345678);
    chk("collision_i_rdata", bus.if_rdata, 32'hE3A01005);

    // Store then load same address
    d_q.push_back('{1'b1, 32'h80, 32'hCAFEF00D});
    d_q.push_back('{1'b0, 32'h80, 32'h0});
    run(5);
    chk("store_load_data", bus.d_rdata, 32'hCAFEF00D);

    // Back-to-back fetches
    f_q.push_back(32'h0); f_q.push_back(32'h4); f_q.push_back(32'h8);
    run(6);

    // Reset while a load is in flight
    d_q.push_back('{1'b0, 32'h44, 32'h0});
    run(1);
    nreset = 1'b0;
    run(2);
    nreset = 1'b1;
    run(4);

    // Continuous data traffic against one fetch
    d_forever = 1'b1;
    f_q.push_back(32'h10);
    first = 0; n_ifg = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (obs_ifg) begin n_ifg++; if (first == 0) first = k; end
    end
    chk("starve_first_gnt", first, STARVE_EN ? 5 : 0);
    chk("starve_gnt_count", n_ifg, STARVE_EN ? 1 : 0);
    d_forever = 1'b0;
    run(6);

    // Random mixed traffic
    for (int k = 0; k < 400; k++) begin
      if (f_q.size() < 2 && $urandom_range(0, 2) == 0)
        f_q.push_back({22'h0, 8'($urandom_range(0, 255)), 2'b00});
      if (d_q.size() < 2 && $urandom_range(0, 2) == 0)
        d_q.push_back('{1'($urandom_range(0, 1)), {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom});
      step();
    end
    run(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
